// File: rtl/tcm_mem_ram_ctrl.sv
// tcm_mem_ram_ctrl: arbitrates bridge and debug ports onto one single-port TCM SRAM with fixed-latency tagged acks.
// Optional TCM_RAM_RANGE_CHK_EN: out-of-range accesses are granted but skip the SRAM and return an error response.
module tcm_mem_ram_ctrl #(
  parameter int          ADDR_W     = 16,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ram_wr_i,
  input  logic              ram_rd_i,
  input  logic [7:0]        ram_len_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [31:0]       ram_write_data_i,
  output logic              ram_accept_o,
  output logic              ram_ack_o,
  output logic              ram_error_o,
  output logic [31:0]       ram_read_data_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  input  logic [3:0]        dbg_wstrb_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [31:0]       dbg_rdata_o,
  output logic              sram_ce_o,
  output logic [3:0]        sram_we_o,
  output logic [ADDR_W-3:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  input  logic              sram_busy_i
);
  logic        bridge_req, ram_go, go, in_range;
  logic [31:0] addr, rdata;
  logic [2:0]  stage_d, head;
  logic [2:0]  pipe_q [RD_LATENCY];
  logic        unused_ok;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign bridge_req   = ram_rd_i | (|ram_wr_i);
  assign dbg_gnt_o    = rst_n & ~sram_busy_i & dbg_req_i;
  assign ram_accept_o = rst_n & ~sram_busy_i & ~dbg_req_i;
  assign ram_go       = ram_accept_o & bridge_req;
  assign go           = dbg_gnt_o | ram_go;
  assign addr         = dbg_gnt_o ? dbg_addr_i : ram_addr_i;

`ifdef TCM_RAM_RANGE_CHK_EN
  logic [32:0] off;
  assign off      = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range = ~off[32] && ((off[31:0] >> ADDR_W) == 32'h0);
`else
  assign in_range = 1'b1;
`endif

  assign sram_ce_o    = go & in_range;
  assign sram_we_o    = !sram_ce_o ? 4'h0 : dbg_gnt_o ? (dbg_we_i ? dbg_wstrb_i : 4'h0) : ram_wr_i;
  assign sram_addr_o  = sram_ce_o ? addr[ADDR_W-1:2] : '0;
  assign sram_wdata_o = !sram_ce_o ? 32'h0 : dbg_gnt_o ? dbg_wdata_i : ram_write_data_i;

  // Pipeline entry: {valid, src_is_debug, err}; shifts every cycle, never stalls.
  assign stage_d = {go, dbg_gnt_o, go & ~in_range};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= 3'b000;
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign head            = pipe_q[RD_LATENCY-1];
  assign rdata           = head[0] ? 32'h0 : sram_rdata_i;
  assign ram_ack_o       = head[2] & ~head[1];
  assign dbg_rvalid_o    = head[2] & head[1];
  assign ram_read_data_o = ram_ack_o ? rdata : 32'h0;
  assign dbg_rdata_o     = dbg_rvalid_o ? rdata : 32'h0;

`ifdef TCM_RAM_RANGE_CHK_EN
  assign ram_error_o = ram_ack_o & head[0];
`else
  assign ram_error_o = 1'b0;
`endif

  assign unused_ok = ^{ram_len_i, addr[31:ADDR_W], addr[1:0]};
endmodule

// File: tb/tb_tcm_mem_ram_ctrl.sv
// tb_tcm_mem_ram_ctrl: directed bench driving latency-1 and latency-3 controllers with shared stimulus and SRAM models.
module tb_tcm_mem_ram_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  ram_wr = 4'h0, dbg_wstrb = 4'h0;
  logic        ram_rd = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, busy = 1'b0;
  logic [31:0] ram_addr = 32'h0, ram_wdata = 32'h0, dbg_addr = 32'h0, dbg_wdata = 32'h0;
  logic        a1_acc, a1_ack, a1_err, a1_gnt, a1_rv, a1_ce;
  logic        a3_acc, a3_ack, a3_err, a3_gnt, a3_rv, a3_ce;
  logic [31:0] a1_rd, a1_drd, a1_wd, a3_rd, a3_drd, a3_wd;
  logic [3:0]  a1_we, a3_we;
  logic [13:0] a1_a, a3_a;
  logic [31:0] mem1 [0:16383];
  logic [31:0] mem3 [0:16383];
  logic [31:0] rd1_q;
  logic [31:0] rd3_q [3];
  int          tests = 0, fails = 0;
  logic [10:0] rd_v, busy_v, exp_ce, exp_ack;

  always #5 clk = ~clk;

  tcm_mem_ram_ctrl #(.ADDR_W(16), .RD_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ram_wr_i(ram_wr), .ram_rd_i(ram_rd), .ram_len_i(8'h0),
    .ram_addr_i(ram_addr), .ram_write_data_i(ram_wdata), .ram_accept_o(a1_acc), .ram_ack_o(a1_ack),
    .ram_error_o(a1_err), .ram_read_data_o(a1_rd), .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_wstrb_i(dbg_wstrb), .dbg_gnt_o(a1_gnt),
    .dbg_rvalid_o(a1_rv), .dbg_rdata_o(a1_drd), .sram_ce_o(a1_ce), .sram_we_o(a1_we),
    .sram_addr_o(a1_a), .sram_wdata_o(a1_wd), .sram_rdata_i(rd1_q), .sram_busy_i(busy));

  tcm_mem_ram_ctrl #(.ADDR_W(16), .RD_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .ram_wr_i(ram_wr), .ram_rd_i(ram_rd), .ram_len_i(8'h0),
    .ram_addr_i(ram_addr), .ram_write_data_i(ram_wdata), .ram_accept_o(a3_acc), .ram_ack_o(a3_ack),
    .ram_error_o(a3_err), .ram_read_data_o(a3_rd), .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_wstrb_i(dbg_wstrb), .dbg_gnt_o(a3_gnt),
    .dbg_rvalid_o(a3_rv), .dbg_rdata_o(a3_drd), .sram_ce_o(a3_ce), .sram_we_o(a3_we),
    .sram_addr_o(a3_a), .sram_wdata_o(a3_wd), .sram_rdata_i(rd3_q[2]), .sram_busy_i(busy));

  // SRAM models: read data valid 1 and 3 cycles after ce respectively.
  always @(posedge clk) begin
    if (a1_ce) begin
      rd1_q <= mem1[a1_a];
      for (int b = 0; b < 4; b++) if (a1_we[b]) mem1[a1_a][8*b +: 8] <= a1_wd[8*b +: 8];
    end
    rd3_q[0] <= a3_ce ? mem3[a3_a] : 32'h0;
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
    if (a3_ce) for (int b = 0; b < 4; b++) if (a3_we[b]) mem3[a3_a][8*b +: 8] <= a3_wd[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ram_rd = 1'b1; dbg_req = 1'b1;
    #3;
    chk("rst_accept", {31'h0, a1_acc}, 32'h0);
    chk("rst_gnt", {31'h0, a1_gnt}, 32'h0);
    chk("rst_ce", {31'h0, a1_ce}, 32'h0);
    chk("rst_ack3", {31'h0, a3_ack}, 32'h0);
    ram_rd = 1'b0; dbg_req = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    chk("idle_accept", {31'h0, a1_acc}, 32'h1);
    chk("idle_ce", {31'h0, a1_ce}, 32'h0);
    tick;
    // preload via debug writes
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEADBEEF; dbg_wstrb = 4'hF;
    #1;
    chk("dw_gnt", {31'h0, a1_gnt}, 32'h1);
    chk("dw_accept", {31'h0, a1_acc}, 32'h0);
    chk("dw_we", {28'h0, a1_we}, 32'hF);
    chk("dw_addr", {18'h0, a1_a}, 32'h4);
    chk("dw_wdata", a1_wd, 32'hDEADBEEF);
    tick;
    dbg_addr = 32'h20; dbg_wdata = 32'hAAAAAAAA;
    #1;
    chk("dw_ack1", {31'h0, a1_rv}, 32'h1);
    chk("dw_noack_bridge", {31'h0, a1_ack}, 32'h0);
    tick;
    dbg_addr = 32'h10; dbg_wdata = 32'h0; dbg_wstrb = 4'h0;
    #1;
    chk("dw_ack2", {31'h0, a1_rv}, 32'h1);
    chk("dz_ce", {31'h0, a1_ce}, 32'h1);
    chk("dz_we", {28'h0, a1_we}, 32'h0);
    tick;
    dbg_req = 1'b0; dbg_we = 1'b0;
    #1;
    chk("dz_ack", {31'h0, a1_rv}, 32'h1);
    tick;
    // bridge read of word 4
    ram_rd = 1'b1; ram_addr = 32'h10;
    #1;
    chk("br_accept", {31'h0, a1_acc}, 32'h1);
    chk("br_ce", {31'h0, a1_ce}, 32'h1);
    chk("br_addr", {18'h0, a1_a}, 32'h4);
    chk("br_we", {28'h0, a1_we}, 32'h0);
    tick;
    ram_rd = 1'b0;
    #1;
    chk("br_ack", {31'h0, a1_ack}, 32'h1);
    chk("br_data", a1_rd, 32'hDEADBEEF);
    chk("br_dbg_quiet", a1_drd, 32'h0);
    tick;
    chk("br_ack_done", {31'h0, a1_ack}, 32'h0);
    chk("br_data_zero", a1_rd, 32'h0);
    tick;
    chk("br_ack3", {31'h0, a3_ack}, 32'h1);
    chk("br_data3", a3_rd, 32'hDEADBEEF);
    // bridge partial write then read back
    ram_wr = 4'b0011; ram_addr = 32'h20; ram_wdata = 32'h12345678;
    #1;
    chk("bw_we", {28'h0, a1_we}, 32'h3);
    chk("bw_addr", {18'h0, a1_a}, 32'h8);
    chk("bw_wdata", a1_wd, 32'h12345678);
    tick;
    ram_wr = 4'h0; ram_rd = 1'b1;
    #1;
    chk("bw_ack", {31'h0, a1_ack}, 32'h1);
    chk("bw_err", {31'h0, a1_err}, 32'h0);
    tick;
    ram_rd = 1'b0;
    #1;
    chk("bw_readback", a1_rd, 32'hAAAA5678);
    tick;
    // debug priority over a pending bridge read
    dbg_req = 1'b1; dbg_addr = 32'h10; ram_rd = 1'b1; ram_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pr_gnt", {31'h0, a1_gnt}, 32'h1);
      chk("pr_accept", {31'h0, a1_acc}, 32'h0);
      tick;
      chk("pr_rvalid", {31'h0, a1_rv}, 32'h1);
      chk("pr_rdata", a1_drd, 32'hDEADBEEF);
      chk("pr_no_ack", {31'h0, a1_ack}, 32'h0);
    end
    dbg_req = 1'b0;
    #1;
    chk("pr_accept4", {31'h0, a1_acc}, 32'h1);
    tick;
    ram_rd = 1'b0;
    chk("pr_ack", {31'h0, a1_ack}, 32'h1);
    chk("pr_ack_data", a1_rd, 32'hAAAA5678);
    chk("pr_rvalid_done", {31'h0, a1_rv}, 32'h0);
    tick; tick; tick; tick;
    // latency 3 with busy window after the 2nd grant
    rd_v = 11'b00001111111; busy_v = 11'b00000011100;
    exp_ce = 11'b00001100011; exp_ack = 11'b01100011000;
    ram_addr = 32'h10;
    for (int c = 0; c < 11; c++) begin
      ram_rd = rd_v[c]; busy = busy_v[c];
      #1;
      chk("bz_ce", {31'h0, a3_ce}, {31'h0, exp_ce[c]});
      chk("bz_accept", {31'h0, a3_acc}, {31'h0, ~busy_v[c]});
      chk("bz_ack", {31'h0, a3_ack}, {31'h0, exp_ack[c]});
      chk("bz_data", a3_rd, exp_ack[c] ? 32'hDEADBEEF : 32'h0);
      tick;
    end
    ram_rd = 1'b0; busy = 1'b0;
    tick; tick; tick;
    // reset one cycle after a read grant drops the in-flight ack
    ram_rd = 1'b1; ram_addr = 32'h10;
    tick;
    ram_rd = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_ack3", {31'h0, a3_ack}, 32'h0);
    chk("mr_accept", {31'h0, a3_acc}, 32'h0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mr_no_ack3", {31'h0, a3_ack}, 32'h0);
      chk("mr_no_ack1", {31'h0, a1_ack}, 32'h0);
      tick;
    end
    // access above the TCM window
    ram_rd = 1'b1; ram_addr = 32'h0001_0010;
    #1;
`ifdef TCM_RAM_RANGE_CHK_EN
    chk("oor_ce", {31'h0, a1_ce}, 32'h0);
    chk("oor_accept", {31'h0, a1_acc}, 32'h1);
    tick;
    ram_rd = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0002_0000;
    chk("oor_ack", {31'h0, a1_ack}, 32'h1);
    chk("oor_err", {31'h0, a1_err}, 32'h1);
    chk("oor_data", a1_rd, 32'h0);
    #1;
    chk("oor_dbg_ce", {31'h0, a1_ce}, 32'h0);
    tick;
    dbg_req = 1'b0;
    chk("oor_dbg_rv", {31'h0, a1_rv}, 32'h1);
    chk("oor_dbg_data", a1_drd, 32'h0);
    chk("oor_dbg_no_err", {31'h0, a1_err}, 32'h0);
`else
    chk("alias_ce", {31'h0, a1_ce}, 32'h1);
    chk("alias_addr", {18'h0, a1_a}, 32'h4);
    tick;
    ram_rd = 1'b0;
    chk("alias_ack", {31'h0, a1_ack}, 32'h1);
    chk("alias_err", {31'h0, a1_err}, 32'h0);
    chk("alias_data", a1_rd, 32'hDEADBEEF);
`endif
    tick; tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tcm_mem_ram_ctrl.md
Name: tcm_mem_ram_ctrl

Overview:
- Downstream stage of the TCM AXI-to-RAM bridge; consumes its ram_* request stream and drives one synchronous single-port SRAM macro that holds the TCM.
- Adds a debug/boot-loader port with strict priority over the bridge.
- Returns one ack per accepted request (read or write) after a fixed, parameterised read latency.
- Tags every in-flight access with its source port so each response is routed back to the originator.

Parameters:
- ADDR_W, 16: TCM byte-address bits; size 2^ADDR_W bytes; SRAM word address is ADDR_W-2 bits.
- RD_LATENCY, 1: SRAM read latency in cycles; legal 1..3.
- BASE_ADDR, 32'h0000_0000: TCM base address; used only by the optional range check.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ram_wr_i  in  4  byte write strobes from bridge; nonzero = write request
- ram_rd_i  in  1  read request from bridge
- ram_len_i  in  8  burst length; always 0; ignored
- ram_addr_i  in  32  byte address
- ram_write_data_i  in  32  write data
- ram_accept_o  out  1  bridge request accepted this cycle
- ram_ack_o  out  1  bridge response valid, one cycle per accepted request
- ram_error_o  out  1  bridge response error
- ram_read_data_o  out  32  bridge read data, valid with ram_ack_o
- dbg_req_i  in  1  debug port request
- dbg_we_i  in  1  debug write (1) / read (0)
- dbg_addr_i  in  32  debug byte address
- dbg_wdata_i  in  32  debug write data
- dbg_wstrb_i  in  4  debug byte strobes; ignored on reads
- dbg_gnt_o  out  1  debug request accepted this cycle
- dbg_rvalid_o  out  1  debug response valid; pulses for reads and writes
- dbg_rdata_o  out  32  debug read data
- sram_ce_o  out  1  SRAM chip enable
- sram_we_o  out  4  SRAM byte write enables
- sram_addr_o  out  ADDR_W-2  SRAM word address = addr[ADDR_W-1:2]
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, valid RD_LATENCY cycles after ce
- sram_busy_i  in  1  SRAM unavailable (retention/BIST); blocks new grants

Behaviour:
- Reset values: all outputs 0; response pipeline cleared. Reset mid-operation drops all in-flight accesses; no ack is issued for them after reset.
- Bridge request present: ram_rd_i | (|ram_wr_i). Simultaneous rd and wr from the bridge is illegal and is not checked.
- Arbitration is combinational, same cycle:
  - sram_busy_i=1: dbg_gnt_o=0, ram_accept_o=0, sram_ce_o=0.
  - Otherwise dbg_req_i=1: dbg_gnt_o=1, ram_accept_o=0.
  - Otherwise: ram_accept_o=1 unconditionally, asserted even with no bridge request; the bridge samples it with its own request.
- The SRAM is driven in the grant cycle T:
  - sram_ce_o=1.
  - sram_we_o = strobes of the granted write, or 0 for a read.
  - A write with all-zero strobes is a no-op; it is still acked.
- Response pipeline: RD_LATENCY-deep shift register of {valid, src, err}, shifted every cycle and never stalled; sram_busy_i blocks only new grants.
- At T+RD_LATENCY:
  - src=bridge: ram_ack_o=1 and ram_read_data_o=sram_rdata_i.
  - src=debug: dbg_rvalid_o=1 and dbg_rdata_o=sram_rdata_i.
  - Read-data outputs are 0 when the corresponding valid is 0.
- Throughput: one access per cycle. Back-to-back grants produce back-to-back acks in grant order, with no reordering between ports.
- Writes are also acked at T+RD_LATENCY. The bridge depends on this to pop its request tracker.
- No backpressure on acks; the bridge has at most 4 accesses outstanding.
- Address: bits above ADDR_W-1 are ignored without the optional feature (aliasing).

Optional Feature:
- Macro: TCM_RAM_RANGE_CHK_EN.
- Defined: an access whose address is outside [BASE_ADDR, BASE_ADDR + 2^ADDR_W) is still granted, but sram_ce_o=0 in the grant cycle. Its response arrives at the same latency with err=1 and read data forced to 0. ram_error_o=1 for bridge-sourced errors; debug-sourced errors are only visible as data 0.
- Undefined: ram_error_o tied to 0, no comparator, addresses alias.

Test Plan:
- Bridge read, RD_LATENCY=1, addr 0x10, SRAM word 4 = 0xDEADBEEF -> sram_ce_o=1 and sram_addr_o=4 at T; ram_ack_o=1 and ram_read_data_o=0xDEADBEEF at T+1.
- Bridge write with strobes 4'b0011 to 0x20, data 0x12345678, then read of 0x20 with prior contents 0xAAAAAAAA -> read returns 0xAAAA5678; write ack at T+1.
- dbg_req_i and ram_rd_i together for 3 cycles -> dbg_gnt_o=1 and ram_accept_o=0 for all 3; bridge read granted on cycle 4; dbg_rvalid_o pulses x3, then ram_ack_o x1, in grant order.
- RD_LATENCY=3, 4 back-to-back bridge reads with sram_busy_i raised after the 2nd grant -> exactly 2 acks at T+3 and T+4, no further grants while busy, remaining 2 reads granted and acked after busy drops.
- rst_n pulsed low 1 cycle after a read grant with RD_LATENCY=2 -> no ram_ack_o follows; all outputs 0 during and after reset.
- TCM_RAM_RANGE_CHK_EN, ADDR_W=16, BASE_ADDR=0, bridge read at 0x0001_0000 -> sram_ce_o=0; ram_ack_o=1, ram_error_o=1, data 0 at T+RD_LATENCY.
